pipe_stage_buff: RTL and testbench

//   Parametrised pipeline-stage register for the 16-bit datapath. Successor to the fixed
//   4-field stage buffers. Carries NUM_FIELDS fields of FIELD_W bits between pipeline stages.

---
 rtl/pipe_buff_pkg.sv | 28 ++
 rtl/pipe_stage_buff_if.sv | 28 ++
 rtl/pipe_buff_entry.sv | 21 ++
 rtl/pipe_stage_buff.sv | 124 ++++++++++++
 tb/tb_pipe_stage_buff.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_buff_pkg.sv
// Shared types and constants for the parametrised pipeline-stage buffer.
// Holds the state encoding, default geometry and the NOP bus builder.
package pipe_buff_pkg;

  localparam int FIELD_W_DEF    = 16;
  localparam int NUM_FIELDS_DEF = 4;
  localparam int CNT_W_DEF      = 16;
  localparam int MAX_BUS_W      = 512;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pb_state_t;

  // word must arrive zero-extended beyond field_w so shifted copies do not overlap.
  function automatic logic [MAX_BUS_W-1:0] nop_fill(input logic [MAX_BUS_W-1:0] word,
                                                    input int field_w,
                                                    input int num_fields);
    logic [MAX_BUS_W-1:0] r;
    r = '0;
    for (int k = 0; k < num_fields; k++) begin
      r = r | (word << (k * field_w));
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_buff_if.sv
// Valid/ready bus between two pipeline stages, both sides in one bundle.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
interface pipe_stage_buff_if
  import pipe_buff_pkg::*;
#(
  parameter int FIELD_W    = FIELD_W_DEF,
  parameter int NUM_FIELDS = NUM_FIELDS_DEF
);
  localparam int BUS_W = FIELD_W * NUM_FIELDS;

  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_buff_entry.sv
// One held entry of the stage buffer: wide register with load enable and sync clear.
module pipe_buff_entry #(
  parameter int           W       = 64,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= CLR_VAL;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buff.sv
// Pipeline-stage buffer with a 2-entry skid so in_ready comes straight from a flop.
// Flush squashes held entries; stall_cnt counts back-pressured cycles and saturates.
module pipe_stage_buff
  import pipe_buff_pkg::*;
#(
  parameter int                 FIELD_W    = FIELD_W_DEF,
  parameter int                 NUM_FIELDS = NUM_FIELDS_DEF,
  parameter logic [FIELD_W-1:0] NOP_WORD   = '0,
  parameter int                 CNT_W      = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  pipe_stage_buff_if.slave   bus,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt,
  output pb_state_t          state_dbg
);

  localparam int               BUS_W   = FIELD_W * NUM_FIELDS;
  localparam logic [BUS_W-1:0] NOP_BUS = BUS_W'(nop_fill(MAX_BUS_W'(NOP_WORD), FIELD_W, NUM_FIELDS));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pb_state_t        state, state_nxt;
  logic             in_ready_q, out_valid_q;
  logic             push, pop;
  logic             main_ld, main_from_skid, skid_ld;
  logic [BUS_W-1:0] main_q, skid_q, main_d;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = ONE;
            main_ld   = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_ld = 1'b1;
          end else if (push) begin
            state_nxt = FULL;
            skid_ld   = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (pop) begin
            state_nxt      = ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid_q && !bus.out_ready && !flush && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign main_d = main_from_skid ? skid_q : bus.in_data;

  pipe_buff_entry #(.W(BUS_W), .CLR_VAL(NOP_BUS)) u_main (
    .clk (clk),
    .clr (rst),
    .ld  (main_ld),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_buff_entry #(.W(BUS_W), .CLR_VAL(NOP_BUS)) u_skid (
    .clk (clk),
    .clr (rst),
    .ld  (skid_ld),
    .d   (bus.in_data),
    .q   (skid_q)
  );

  always_comb begin
    occupancy = 2'd0;
    case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_valid_q ? main_q : NOP_BUS;
  assign state_dbg     = state;

endmodule

// File: tb/tb_pipe_stage_buff.sv
// Bench for pipe_stage_buff: a default build and a 6-field, 3-bit-counter build
// run on identical stimulus against a queue model of the buffer.
module tb_pipe_stage_buff;
  import pipe_buff_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0] in_word = 16'h0000;
  logic mon_en = 1'b0;

  pipe_stage_buff_if #(.FIELD_W(16), .NUM_FIELDS(4)) bus_a ();
  pipe_stage_buff_if #(.FIELD_W(16), .NUM_FIELDS(6)) bus_b ();

  logic [1:0]  occ_a, occ_b;
  logic [15:0] stall_a;
  logic [2:0]  stall_b;
  pb_state_t   st_a, st_b;

  logic [15:0] exp_q[$];
  int          exp_stall_a, exp_stall_b;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [95:0] make_bus(input logic [15:0] w);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) begin
      r[k*16 +: 16] = w ^ (16'(k) << 12);
    end
    return r;
  endfunction

  logic [95:0] drv_bus;
  assign drv_bus         = make_bus(in_word);
  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = drv_bus[63:0];
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = drv_bus;
  assign bus_b.out_ready = out_ready;

  pipe_stage_buff #(.FIELD_W(16), .NUM_FIELDS(4), .NOP_WORD(16'h0000), .CNT_W(16)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus_a.slave),
    .occupancy (occ_a),
    .stall_cnt (stall_a),
    .state_dbg (st_a)
  );

  pipe_stage_buff #(.FIELD_W(16), .NUM_FIELDS(6), .NOP_WORD(16'h0000), .CNT_W(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus_b.slave),
    .occupancy (occ_b),
    .stall_cnt (stall_b),
    .state_dbg (st_b)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: advances on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    bit do_push, do_pop;
    if (rst) begin
      exp_q.delete();
      exp_stall_a = 0;
      exp_stall_b = 0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      do_pop  = (exp_q.size() > 0) && out_ready;
      do_push = in_valid && (exp_q.size() < 2);
      if (exp_q.size() > 0 && !out_ready) begin
        if (exp_stall_a < 65535) exp_stall_a++;
        if (exp_stall_b < 7) exp_stall_b++;
      end
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(in_word);
    end
  end

  // Output monitor on the falling edge, against the model state.
  always @(negedge clk) begin
    logic        ev;
    logic [95:0] eb;
    logic [63:0] ea;
    pb_state_t   es;
    if (mon_en) begin
      ev = (exp_q.size() > 0);
      eb = ev ? make_bus(exp_q[0]) : 96'h0;
      ea = eb[63:0];
      es = (exp_q.size() == 0) ? EMPTY : (exp_q.size() == 1) ? ONE : FULL;
      check("valid_a", bus_a.out_valid, ev);
      check("ready_a", bus_a.in_ready, exp_q.size() < 2);
      check("occ_a",   occ_a, exp_q.size());
      check("state_a", st_a, es);
      check("data_a",  bus_a.out_data, ea);
      check("stall_a", stall_a, exp_stall_a);
      check("valid_b", bus_b.out_valid, ev);
      check("ready_b", bus_b.in_ready, exp_q.size() < 2);
      check("occ_b",   occ_b, exp_q.size());
      check("data_b",  bus_b.out_data, eb);
      check("stall_b", stall_b, exp_stall_b);
    end
  end

  task automatic drive(input logic iv, input logic [15:0] w, input logic ordy, input logic fl);
    in_valid  = iv;
    in_word   = w;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset, then check idle outputs.
    do_reset(2);
    mon_en = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    check("rst_data_a", bus_a.out_data, 96'h0);

    // Streaming with out_ready high.
    drive(1'b1, 16'hA001, 1'b1, 1'b0);
    drive(1'b1, 16'hA002, 1'b1, 1'b0);
    drive(1'b1, 16'hA003, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);

    // Fill to FULL under back-pressure, then drain.
    drive(1'b1, 16'hB001, 1'b0, 1'b0);
    drive(1'b1, 16'hB002, 1'b0, 1'b0);
    check("full_occ", occ_a, 2'd2);
    check("full_rdy", bus_a.in_ready, 1'b0);
    drive(1'b1, 16'hBBAD, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 16'h0000, 1'b1, 1'b0);

    // Stall five cycles in FULL, then flush with a simultaneous push.
    do_reset(1);
    drive(1'b1, 16'hC001, 1'b0, 1'b0);
    drive(1'b1, 16'hC002, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 16'h0000, 1'b0, 1'b0);
    check("stall5", stall_a, 16'd5);
    drive(1'b1, 16'hD001, 1'b0, 1'b1);
    check("flush_occ", occ_a, 2'd0);
    check("flush_stall", stall_a, 16'd5);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);

    // Saturation of the 3-bit counter.
    do_reset(1);
    drive(1'b1, 16'hE001, 1'b0, 1'b0);
    repeat (10) drive(1'b0, 16'h0000, 1'b0, 1'b0);
    check("sat_b", stall_b, 3'd7);
    check("nosat_a", stall_a, 16'd10);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);

    // Random traffic with occasional flush.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    // Reset while FULL with flush and push asserted.
    drive(1'b1, 16'hF001, 1'b0, 1'b0);
    drive(1'b1, 16'hF002, 1'b0, 1'b0);
    drive(1'b1, 16'hF003, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_word  = 16'hF004;
    flush    = 1'b1;
    do_reset(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("rst_full_occ", occ_a, 2'd0);
    check("rst_full_rdy", bus_a.in_ready, 1'b1);
    check("rst_full_stall", stall_a, 16'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
